// File: rtl/sha256_digest_collector_if.sv
// Bundle between the digest collector and its neighbours: word input from
// sha256_reduced, compare/status outputs and the ASCII hex byte stream.
interface sha256_digest_collector_if;
   logic [31:0]  hash_out;
   logic         hash_valid;
   logic [255:0] expected;
   logic         cmp_en;
   logic [255:0] digest;
   logic         digest_valid;
   logic         match;
   logic         timeout_err;
   logic         overrun;
   logic         busy;
   logic [7:0]   hex_data;
   logic         hex_valid;
   logic         hex_ready;
   logic         hex_last;

   modport master (
      output hash_out, hash_valid, expected, cmp_en, hex_ready,
      input  digest, digest_valid, match, timeout_err, overrun, busy,
             hex_data, hex_valid, hex_last
   );

   modport slave (
      input  hash_out, hash_valid, expected, cmp_en, hex_ready,
      output digest, digest_valid, match, timeout_err, overrun, busy,
             hex_data, hex_valid, hex_last
   );
endinterface

// File: rtl/sha256_digest_collector.sv
// Collects eight 32-bit digest words into a 256-bit digest, optionally compares
// it against a reference, then streams it as 64 ASCII hex characters.
module sha256_digest_collector #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter bit HEX_UPPER      = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   sha256_digest_collector_if.slave    bus
);

   localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, EMIT} state_t;

   state_t         state, state_next;
   logic [255:0]   shadow, expected_q, digest;
   logic           cmp_en_q;
   logic [3:0]     wcnt;
   logic [5:0]     ccnt;
   logic [TW-1:0]  tcnt;
   logic           digest_valid, match, timeout_err, overrun, busy;
   logic [7:0]     hex_data;
   logic           hex_valid, hex_last;
   logic           handshake, last_word, timeout_hit, emit_done;

   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'd0, n};
      return (HEX_UPPER ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
   endfunction

   function automatic logic [3:0] nibble_at(input logic [255:0] d, input logic [5:0] idx);
      return d[255 - 4*int'(idx) -: 4];
   endfunction

   always_comb begin
      handshake   = hex_valid && bus.hex_ready;
      last_word   = bus.hash_valid && (wcnt == 4'd7);
      timeout_hit = !bus.hash_valid && (tcnt == TLIM);
      emit_done   = handshake && (ccnt == 6'd63);
      state_next  = state;
      case (state)
         IDLE:    if (bus.hash_valid) state_next = COLLECT;
         COLLECT: if (last_word) state_next = COMPARE;
                  else if (timeout_hit) state_next = IDLE;
         COMPARE: state_next = EMIT;
         EMIT:    if (emit_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: shadow is a pure data holding register; every word is written before
   // it is read, so it carries no reset and only the control/outputs are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         expected_q   <= '0;
         cmp_en_q     <= 1'b0;
         wcnt         <= '0;
         ccnt         <= '0;
         tcnt         <= '0;
         digest       <= '0;
         digest_valid <= 1'b0;
         match        <= 1'b0;
         timeout_err  <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
         hex_data     <= '0;
         hex_valid    <= 1'b0;
         hex_last     <= 1'b0;
      end else begin
         digest_valid <= 1'b0;
         match        <= 1'b0;
         timeout_err  <= 1'b0;
         busy         <= (state_next != IDLE);
         case (state)
            IDLE: if (bus.hash_valid) begin
               shadow[255:224] <= bus.hash_out;
               wcnt            <= 4'd1;
               tcnt            <= '0;
               expected_q      <= bus.expected;
               cmp_en_q        <= bus.cmp_en;
            end
            COLLECT: begin
               if (bus.hash_valid) begin
                  shadow[255 - 32*int'(wcnt) -: 32] <= bus.hash_out;
                  wcnt <= wcnt + 4'd1;
                  tcnt <= '0;
               end else if (timeout_hit) begin
                  timeout_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            COMPARE: begin
               digest       <= shadow;
               digest_valid <= 1'b1;
               match        <= cmp_en_q && (shadow == expected_q);
               ccnt         <= '0;
            end
            EMIT: begin
               // The first character is loaded one cycle after entry; afterwards
               // each handshake preloads the next so the sink sees one per cycle.
               if (!hex_valid) begin
                  hex_valid <= 1'b1;
                  hex_data  <= to_ascii(nibble_at(digest, ccnt));
                  hex_last  <= (ccnt == 6'd63);
               end else if (bus.hex_ready) begin
                  if (ccnt == 6'd63) begin
                     hex_valid <= 1'b0;
                     hex_last  <= 1'b0;
                  end else begin
                     ccnt     <= ccnt + 6'd1;
                     hex_data <= to_ascii(nibble_at(digest, ccnt + 6'd1));
                     hex_last <= (ccnt == 6'd62);
                  end
               end
            end
            default: ;
         endcase
         if (bus.hash_valid && (state == COMPARE || state == EMIT)) overrun <= 1'b1;
      end
   end

   assign bus.digest       = digest;
   assign bus.digest_valid = digest_valid;
   assign bus.match        = match;
   assign bus.timeout_err  = timeout_err;
   assign bus.overrun      = overrun;
   assign bus.busy         = busy;
   assign bus.hex_data     = hex_data;
   assign bus.hex_valid    = hex_valid;
   assign bus.hex_last     = hex_last;

endmodule

// File: tb/tb_sha256_digest_collector.sv
// Directed bench for sha256_digest_collector: collection, compare, hex stream,
// backpressure, timeout, overrun and mid-operation reset.
module tb_sha256_digest_collector;

   localparam logic [255:0] D = 256'hc21919e5_b04c8a06_164b68bd_57293a97_c7ef18d7_371feea6_8f3872cd_cb23b743;
   localparam logic [31:0] WORDS [8] = '{32'hc21919e5, 32'hb04c8a06, 32'h164b68bd, 32'h57293a97,
                                         32'hc7ef18d7, 32'h371feea6, 32'h8f3872cd, 32'hcb23b743};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] rx_chars [64];
   int rx_n, rx_stall_bad, rx_last_bad, rx_dv, rx_first, rx_cyc;

   sha256_digest_collector_if bus();

   sha256_digest_collector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input int max_gap, input int count);
      for (int i = 0; i < count; i++) begin
         bus.hash_out   = WORDS[i];
         bus.hash_valid = 1'b1;
         tick();
         bus.hash_valid = 1'b0;
         bus.hash_out   = '0;
         if (i < count - 1) repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic wait_digest(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!bus.digest_valid && cyc < 50);
      if (!bus.digest_valid) cyc = -1;
   endtask

   task automatic recv_stream(input bit rnd, input int max_chars);
      logic [7:0] held_d;
      logic       held_l;
      bit         stalled;
      held_d = '0; held_l = 1'b0; stalled = 1'b0;
      rx_n = 0; rx_stall_bad = 0; rx_last_bad = 0; rx_dv = 0; rx_first = -1; rx_cyc = 0;
      while (rx_n < max_chars && rx_cyc < 3000) begin
         bus.hex_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.digest_valid) rx_dv++;
         if (bus.hex_valid) begin
            if (rx_first < 0) rx_first = rx_cyc;
            if (stalled && (bus.hex_data !== held_d || bus.hex_last !== held_l)) rx_stall_bad++;
            if (bus.hex_ready) begin
               rx_chars[rx_n] = bus.hex_data;
               if (bus.hex_last !== 1'(rx_n == 63)) rx_last_bad++;
               rx_n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held_d  = bus.hex_data;
               held_l  = bus.hex_last;
            end
         end
         tick();
         rx_cyc++;
      end
      bus.hex_ready = 1'b0;
   endtask

   // Counts received characters that differ from the lowercase hex text of D.
   function automatic int stream_errors();
      string s;
      int    e;
      s = $sformatf("%h", D);
      e = 0;
      for (int i = 0; i < 64; i++) if (rx_chars[i] !== s[i]) e++;
      return e;
   endfunction

   task automatic test_reset();
      bus.hash_out = '0; bus.hash_valid = 1'b0; bus.expected = '0; bus.cmp_en = 1'b0;
      bus.hex_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_checks++; if (bus.digest !== '0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", bus.digest); end
      n_checks++; if ({bus.digest_valid, bus.match, bus.timeout_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected 000", {bus.digest_valid, bus.match, bus.timeout_err}); end
      n_checks++; if ({bus.overrun, bus.busy} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus.overrun, bus.busy}); end
      n_checks++; if ({bus.hex_valid, bus.hex_last, bus.hex_data} !== 10'd0) begin
         n_fail++; $display("FAIL reset_hex: got %b expected 0", {bus.hex_valid, bus.hex_last, bus.hex_data}); end
   endtask

   task automatic test_basic();
      int cyc;
      bus.expected = D; bus.cmp_en = 1'b1;
      send_words(0, 8);
      wait_digest(cyc);
      n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL basic_dv_latency: got %0d expected 1", cyc); end
      n_checks++; if (bus.digest !== D) begin n_fail++; $display("FAIL basic_digest: got %h expected %h", bus.digest, D); end
      n_checks++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL basic_match: got %b expected 1", bus.match); end
      recv_stream(1'b0, 64);
      n_checks++; if (rx_dv !== 1) begin n_fail++; $display("FAIL basic_dv_pulses: got %0d expected 1", rx_dv); end
      n_checks++; if (rx_first !== 1) begin n_fail++; $display("FAIL basic_hex_latency: got %0d expected 1", rx_first); end
      n_checks++; if (rx_cyc !== 65) begin n_fail++; $display("FAIL basic_stream_cycles: got %0d expected 65", rx_cyc); end
      n_checks++; if ({rx_chars[0], rx_chars[1], rx_chars[2], rx_chars[63]} !== 32'h63323133) begin
         n_fail++; $display("FAIL basic_chars_ends: got %h expected 63323133", {rx_chars[0], rx_chars[1], rx_chars[2], rx_chars[63]}); end
      n_checks++; if (stream_errors() !== 0) begin n_fail++; $display("FAIL basic_stream: got %0d bad chars expected 0", stream_errors()); end
      n_checks++; if (rx_last_bad !== 0) begin n_fail++; $display("FAIL basic_hex_last: got %0d bad expected 0", rx_last_bad); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", bus.busy); end
   endtask

   task automatic test_gapped_backpressure();
      int cyc;
      bus.expected = D; bus.cmp_en = 1'b1;
      send_words(5, 8);
      wait_digest(cyc);
      n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL gap_dv_latency: got %0d expected 1", cyc); end
      n_checks++; if ({bus.digest, bus.match} !== {D, 1'b1}) begin
         n_fail++; $display("FAIL gap_digest: got %h/%b expected %h/1", bus.digest, bus.match, D); end
      recv_stream(1'b1, 64);
      n_checks++; if (rx_n !== 64) begin n_fail++; $display("FAIL gap_count: got %0d expected 64", rx_n); end
      n_checks++; if (stream_errors() !== 0) begin n_fail++; $display("FAIL gap_stream: got %0d bad chars expected 0", stream_errors()); end
      n_checks++; if (rx_stall_bad !== 0) begin n_fail++; $display("FAIL gap_stall_stable: got %0d changes expected 0", rx_stall_bad); end
      n_checks++; if (rx_last_bad !== 0) begin n_fail++; $display("FAIL gap_hex_last: got %0d bad expected 0", rx_last_bad); end
   endtask

   task automatic test_mismatch();
      int cyc;
      bus.expected = D ^ 256'd1; bus.cmp_en = 1'b1;
      send_words(0, 8);
      wait_digest(cyc);
      n_checks++; if ({bus.digest_valid, bus.match} !== 2'b10) begin
         n_fail++; $display("FAIL mismatch_flip: got dv/match %b expected 10", {bus.digest_valid, bus.match}); end
      recv_stream(1'b0, 64);
      bus.expected = D; bus.cmp_en = 1'b0;
      send_words(0, 8);
      wait_digest(cyc);
      n_checks++; if ({bus.digest_valid, bus.match} !== 2'b10) begin
         n_fail++; $display("FAIL mismatch_cmp_off: got dv/match %b expected 10", {bus.digest_valid, bus.match}); end
      recv_stream(1'b0, 64);
      n_checks++; if (rx_n !== 64) begin n_fail++; $display("FAIL mismatch_drain: got %0d expected 64", rx_n); end
   endtask

   task automatic test_timeout();
      int cnt, dv_seen;
      bus.expected = D; bus.cmp_en = 1'b1;
      send_words(0, 3);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_during: got %b expected 1", bus.busy); end
      cnt = 0; dv_seen = 0;
      while (cnt < 1100) begin
         tick();
         cnt++;
         if (bus.digest_valid) dv_seen++;
         if (bus.timeout_err) break;
      end
      n_checks++; if (cnt !== 1000) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 1000", cnt); end
      n_checks++; if (dv_seen !== 0) begin n_fail++; $display("FAIL timeout_no_dv: got %0d expected 0", dv_seen); end
      n_checks++; if (bus.digest !== D) begin n_fail++; $display("FAIL timeout_digest_kept: got %h expected %h", bus.digest, D); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b expected 0", bus.busy); end
      tick();
      n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", bus.timeout_err); end
   endtask

   task automatic test_overrun();
      int cyc;
      bus.expected = D; bus.cmp_en = 1'b1;
      send_words(0, 8);
      wait_digest(cyc);
      fork
         recv_stream(1'b0, 64);
         begin
            repeat (10) tick();
            bus.hash_out = 32'hdeadbeef; bus.hash_valid = 1'b1;
            tick();
            bus.hash_valid = 1'b0; bus.hash_out = '0;
         end
      join
      n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun); end
      n_checks++; if (rx_n !== 64 || stream_errors() !== 0) begin
         n_fail++; $display("FAIL overrun_stream: got %0d chars %0d bad expected 64/0", rx_n, stream_errors()); end
      send_words(0, 8);
      wait_digest(cyc);
      n_checks++; if ({bus.digest_valid, bus.match, bus.digest} !== {2'b11, D}) begin
         n_fail++; $display("FAIL overrun_next: got %b%b %h expected 11 %h", bus.digest_valid, bus.match, bus.digest, D); end
      recv_stream(1'b0, 64);
      n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
   endtask

   task automatic test_reset_mid_op();
      int cyc;
      bus.expected = D; bus.cmp_en = 1'b1;
      send_words(0, 8);
      wait_digest(cyc);
      recv_stream(1'b0, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if ({bus.digest, bus.digest_valid, bus.match, bus.timeout_err, bus.overrun, bus.busy,
                       bus.hex_data, bus.hex_valid, bus.hex_last} !== '0) begin
         n_fail++; $display("FAIL rst_emit: got digest %h flags %b hex %h/%b/%b expected all 0", bus.digest,
                            {bus.digest_valid, bus.match, bus.timeout_err, bus.overrun, bus.busy},
                            bus.hex_data, bus.hex_valid, bus.hex_last); end
      send_words(0, 5);
      bus.hash_out = WORDS[5]; bus.hash_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; bus.hash_valid = 1'b0; bus.hash_out = '0;
      n_checks++; if ({bus.digest, bus.digest_valid, bus.match, bus.timeout_err, bus.overrun, bus.busy,
                       bus.hex_data, bus.hex_valid, bus.hex_last} !== '0) begin
         n_fail++; $display("FAIL rst_collect: got digest %h busy %b expected all 0", bus.digest, bus.busy); end
      repeat (3) tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_collect_idle: got busy %b expected 0", bus.busy); end
      send_words(0, 8);
      wait_digest(cyc);
      n_checks++; if ({bus.digest_valid, bus.match, bus.digest} !== {2'b11, D}) begin
         n_fail++; $display("FAIL rst_fresh_digest: got %b%b %h expected 11 %h", bus.digest_valid, bus.match, bus.digest, D); end
      recv_stream(1'b0, 64);
      n_checks++; if (rx_n !== 64 || stream_errors() !== 0 || rx_last_bad !== 0) begin
         n_fail++; $display("FAIL rst_fresh_stream: got %0d chars %0d bad %0d last-bad expected 64/0/0",
                            rx_n, stream_errors(), rx_last_bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped_backpressure();
      test_mismatch();
      test_timeout();
      test_overrun();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
